// File: rtl/vga_timing_rx.sv
// VGA receive-side timing recovery: rebuilds pixel coordinates from the
// sync pair, qualifies active pixels and tracks lock against nominal timing.
module vga_timing_rx #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       R,
  input  logic       G,
  input  logic       B,
  input  logic       H_SYNC,
  input  logic       V_SYNC,
  output logic       R_out,
  output logic       G_out,
  output logic       B_out,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       line_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SW + V_BP;
  localparam int H_OFF   = H_SW + H_BP;
  localparam int V_OFF   = V_SW + V_BP;

  localparam logic [10:0] C_HMAX  = 11'(2 * H_TOTAL);
  localparam logic [10:0] C_HLAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_VLAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_HLO   = 11'(H_OFF);
  localparam logic [10:0] C_HHI   = 11'(H_OFF + H_ACTIVE);
  localparam logic [10:0] C_VLO   = 11'(V_OFF);
  localparam logic [10:0] C_VHI   = 11'(V_OFF + V_ACTIVE);
  localparam logic        POL     = (SYNC_POL != 0);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_r1, r_g1, r_b1;
  logic        r_hs1, r_vs1, r_hs2, r_vs2;
  logic        r_v1, r_v2;
  logic [10:0] r_h_cnt, r_v_cnt;
  logic        r_line_bad, r_h_seen;

  logic        w_hs_edge, w_vs_edge;
  logic [10:0] w_h_cur, w_v_cur;
  logic        w_act, w_pv;
  logic [9:0]  w_px, w_py;
  logic        w_line_bad, w_frame_good, w_timeout;
  logic        w_lock_nxt, w_to_search;

  // r_v2 marks that the delay copy holds a real sample, so the reset
  // value of the delay registers can never fake an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r1  <= 1'b0;
      r_g1  <= 1'b0;
      r_b1  <= 1'b0;
      r_hs1 <= 1'b0;
      r_vs1 <= 1'b0;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
    end else begin
      r_r1  <= R;
      r_g1  <= G;
      r_b1  <= B;
      r_hs1 <= H_SYNC;
      r_vs1 <= V_SYNC;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_v1  <= 1'b1;
      r_v2  <= r_v1;
    end
  end

  assign w_hs_edge = r_v2 & (r_hs1 == POL) & (r_hs2 != POL);
  assign w_vs_edge = r_v2 & (r_vs1 == POL) & (r_vs2 != POL);

  // w_*_cur is the count belonging to the stage-1 pixel; registers hold
  // the previous pixel's count for the line/frame length checks
  assign w_h_cur = w_hs_edge ? 11'd0 :
                   (r_h_cnt == C_HMAX) ? r_h_cnt :
                   r_h_cnt + 11'd1;
  assign w_v_cur = w_vs_edge ? 11'd0 :
                   w_hs_edge ? r_v_cnt + 11'd1 :
                   r_v_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= 11'd0;
    end else begin
      r_h_cnt <= w_h_cur;
      r_v_cnt <= w_v_cur;
    end
  end

  assign w_act = (w_h_cur >= C_HLO) && (w_h_cur < C_HHI) &&
                 (w_v_cur >= C_VLO) && (w_v_cur < C_VHI);
  assign w_px  = w_act ? 10'(w_h_cur - C_HLO) : 10'd0;
  assign w_py  = w_act ? 10'(w_v_cur - C_VLO) : 10'd0;

  assign w_line_bad   = w_hs_edge & r_h_seen & (r_h_cnt != C_HLAST);
  assign w_frame_good = (r_v_cnt == C_VLAST) & ~r_line_bad & ~w_line_bad;
  assign w_timeout    = (w_h_cur == C_HMAX);

  assign w_lock_nxt = ~w_timeout & (
    ((r_state == LOCKED) & ~w_line_bad &
     ~(w_vs_edge & ~w_frame_good)) |
    ((r_state == CHECK) & w_vs_edge & w_frame_good));
  assign w_to_search = ((r_state == LOCKED) & ~w_lock_nxt) |
                       ((r_state == CHECK) & w_timeout);
  assign w_pv = w_lock_nxt & w_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_line_bad  <= 1'b0;
      r_h_seen    <= 1'b0;
      R_out       <= 1'b0;
      G_out       <= 1'b0;
      B_out       <= 1'b0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      unique case (r_state)
        SEARCH: if (w_vs_edge) r_state <= CHECK;
        CHECK: begin
          if (w_timeout) r_state <= SEARCH;
          else if (w_vs_edge && w_frame_good) r_state <= LOCKED;
        end
        LOCKED: if (!w_lock_nxt) r_state <= SEARCH;
        default: r_state <= SEARCH;
      endcase

      if (w_vs_edge) r_line_bad <= 1'b0;
      else if (w_line_bad) r_line_bad <= 1'b1;

      if (w_to_search) r_h_seen <= 1'b0;
      else if (w_hs_edge) r_h_seen <= 1'b1;

      R_out       <= r_r1 & w_pv;
      G_out       <= r_g1 & w_pv;
      B_out       <= r_b1 & w_pv;
      pixel_x     <= w_px;
      pixel_y     <= w_py;
      pixel_valid <= w_pv;
      frame_start <= w_pv & (w_px == 10'd0) & (w_py == 10'd0);
      locked      <= w_lock_nxt;
      line_err    <= (r_state == LOCKED) & ~w_lock_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: two instances (active-low and active-high sync)
// driven with one logical stream on a reduced 15x8 raster.
module tb_vga_timing_rx;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int IDLE = 1000000;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic       f;
    logic [2:0] c;
  } out_t;

  typedef struct {
    int h; int l; int x; int y; bit v; bit f;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic R, G, B, hs0, vs0, hs1, vs1;
  logic [1:0] Ro, Go, Bo, pv, fs, lk, le;
  logic [9:0] px [2];
  logic [9:0] py [2];

  vga_timing_rx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB),
    .SYNC_POL(0)
  ) u0 (
    .clk(clk), .reset(reset), .R(R), .G(G), .B(B),
    .H_SYNC(hs0), .V_SYNC(vs0),
    .R_out(Ro[0]), .G_out(Go[0]), .B_out(Bo[0]),
    .pixel_x(px[0]), .pixel_y(py[0]),
    .pixel_valid(pv[0]), .frame_start(fs[0]),
    .locked(lk[0]), .line_err(le[0])
  );

  vga_timing_rx #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SW(VS), .V_BP(VB),
    .SYNC_POL(1)
  ) u1 (
    .clk(clk), .reset(reset), .R(R), .G(G), .B(B),
    .H_SYNC(hs1), .V_SYNC(vs1),
    .R_out(Ro[1]), .G_out(Go[1]), .B_out(Bo[1]),
    .pixel_x(px[1]), .pixel_y(py[1]),
    .pixel_valid(pv[1]), .frame_start(fs[1]),
    .locked(lk[1]), .line_err(le[1])
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  int idx = 0;
  int tagv [4];
  logic [2:0] tagc [4];
  int rise_tag [2], err_tag [2], err_cnt [2];
  int pv_cnt [2], fs_cnt [2], rgb_bad [2], lk9 [2];
  logic prev_lk [2];
  out_t cap [2][VT][HT];
  bit zchk = 0, mon_on = 0;
  vec_t tbl [12];

  task automatic check(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic bit win(input int h, input int l);
    return h >= HS + HB && h < HS + HB + HA &&
           l >= VS + VB && l < VS + VB + VA;
  endfunction

  function automatic logic [2:0] rgb(input int h, input int l);
    return {h[0], l[0], h[1] ^ l[1]};
  endfunction

  task automatic observe();
    int t, f, l, h;
    logic [2:0] ec, ac;
    t = (idx >= 2) ? tagv[(idx - 2) % 4] : -1;
    f = t / 10000;
    l = (t / 100) % 100;
    h = t % 100;
    for (int d = 0; d < 2; d++) begin
      if (zchk)
        check($sformatf("reset_zero_d%0d", d),
              int'({Ro[d], Go[d], Bo[d], pv[d], fs[d], lk[d], le[d],
                    px[d], py[d]}), 0);
      if (mon_on) begin
        if (!prev_lk[d] && lk[d]) rise_tag[d] = t;
        prev_lk[d] = lk[d];
        if (le[d]) begin
          err_cnt[d]++;
          err_tag[d] = t;
        end
        if (f == 3) begin
          pv_cnt[d] += int'(pv[d]);
          fs_cnt[d] += int'(fs[d]);
          ec = win(h, l) ? tagc[(idx - 2) % 4] : 3'b000;
          ac = {Ro[d], Go[d], Bo[d]};
          if (ac != ec) rgb_bad[d]++;
          cap[d][l][h] = '{px[d], py[d], pv[d], fs[d], ac};
        end
        if (f == 9) lk9[d] += int'(lk[d]);
      end
    end
    zchk = 0;
  endtask

  task automatic pix(input bit hsa, input bit vsa, input logic [2:0] c,
                     input int tag, input bit rst);
    @(negedge clk);
    observe();
    reset = rst;
    {R, G, B} = c;
    hs0 = ~hsa;
    vs0 = ~vsa;
    hs1 = hsa;
    vs1 = vsa;
    tagv[idx % 4] = tag;
    tagc[idx % 4] = c;
    idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 3'b000, IDLE + i, 1'b0);
  endtask

  task automatic frame(input int f, input int nl, input int sl,
                       input int rl, input int rh);
    int len;
    bit r;
    for (int l = 0; l < nl; l++) begin
      len = (l == sl) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        r = (l == rl) && (h == rh);
        pix(h < HS, l < VS, rgb(h, l), f * 10000 + l * 100 + h, r);
        if (r) zchk = 1;
      end
    end
  endtask

  task automatic clr();
    for (int d = 0; d < 2; d++) begin
      rise_tag[d] = -1;
      err_tag[d] = -1;
      err_cnt[d] = 0;
    end
  endtask

  initial begin
    out_t a, e;
    tbl[0]  = '{0, 0, 0, 0, 0, 0};
    tbl[1]  = '{5, 3, 0, 0, 1, 1};
    tbl[2]  = '{6, 3, 1, 0, 1, 0};
    tbl[3]  = '{12, 3, 7, 0, 1, 0};
    tbl[4]  = '{13, 3, 0, 0, 0, 0};
    tbl[5]  = '{4, 3, 0, 0, 0, 0};
    tbl[6]  = '{5, 6, 0, 3, 1, 0};
    tbl[7]  = '{12, 6, 7, 3, 1, 0};
    tbl[8]  = '{5, 7, 0, 0, 0, 0};
    tbl[9]  = '{8, 2, 0, 0, 0, 0};
    tbl[10] = '{9, 4, 4, 1, 1, 0};
    tbl[11] = '{14, 7, 0, 0, 0, 0};
    for (int d = 0; d < 2; d++) begin
      prev_lk[d] = 1'b0;
      pv_cnt[d] = 0;
      fs_cnt[d] = 0;
      rgb_bad[d] = 0;
      lk9[d] = 0;
    end
    clr();
    reset = 1'b1;
    {R, G, B} = 3'b000;
    {hs0, vs0, hs1, vs1} = 4'b1100;

    for (int i = 0; i < 3; i++) pix(1'b0, 1'b0, 3'b000, IDLE, 1'b1);
    zchk = 1;
    idle(1);
    mon_on = 1;
    idle(6);

    frame(1, VT, -1, -1, -1);
    frame(2, VT, -1, -1, -1);
    frame(3, VT, -1, -1, -1);
    for (int d = 0; d < 2; d++)
      check($sformatf("lock1_d%0d", d), rise_tag[d], 20000);
    clr();

    frame(4, VT, 5, -1, -1);
    frame(5, VT, -1, -1, -1);
    frame(6, VT, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("short_errcnt_d%0d", d), err_cnt[d], 1);
      check($sformatf("short_errat_d%0d", d), err_tag[d], 40600);
      check($sformatf("relock_d%0d", d), rise_tag[d], 60000);
    end
    clr();

    frame(7, VT, -1, -1, -1);
    idle(40);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("tmo_errcnt_d%0d", d), err_cnt[d], 1);
      check($sformatf("tmo_errat_d%0d", d), err_tag[d], IDLE + 15);
      check($sformatf("tmo_dead_d%0d", d), int'({lk[d], pv[d]}), 0);
    end
    clr();

    frame(8, VT - 1, -1, -1, -1);
    frame(9, VT, -1, -1, -1);
    frame(10, VT, -1, 4, 7);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("short_frame_nolock_d%0d", d), lk9[d], 0);
      check($sformatf("lock_after_good_d%0d", d), rise_tag[d], 100000);
      check($sformatf("noerr_s4_d%0d", d), err_cnt[d], 0);
    end
    clr();

    frame(11, VT, -1, -1, -1);
    frame(12, VT, -1, -1, -1);
    idle(4);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("lock_after_rst_d%0d", d), rise_tag[d], 120000);
      check($sformatf("noerr_s5_d%0d", d), err_cnt[d], 0);
      check($sformatf("f3_valid_cnt_d%0d", d), pv_cnt[d], HA * VA);
      check($sformatf("f3_fs_cnt_d%0d", d), fs_cnt[d], 1);
      check($sformatf("f3_rgb_bad_d%0d", d), rgb_bad[d], 0);
      for (int i = 0; i < 12; i++) begin
        a = cap[d][tbl[i].l][tbl[i].h];
        e = '{10'(tbl[i].x), 10'(tbl[i].y), tbl[i].v, tbl[i].f,
              tbl[i].v ? rgb(tbl[i].h, tbl[i].l) : 3'b000};
        check($sformatf("tbl%0d_d%0d", i, d), int'(a), int'(e));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
